uart_tx_frame: RTL and testbench

Parametrised multi-byte UART transmitter. Accepts an `NBYTES`-wide data word on a start request and serialises it as `NBYTES` back-to-back UART characters, then reports completion. It generalises the fixed 40-bit, 5-byte sender in the following ways:

- byte count, baud rate and stop-bit count are parameters;
- byte order is selectable;
- a parity bit can be compiled in;
- busy status and edge-triggered start are added.

It sits between application logic and the `uart_tx` pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_byte_tx.sv | 91 +++++++++
 rtl/uart_tx_frame.sv | 135 +++++++++++++
 tb/tb_uart_tx_frame.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the multi-byte UART transmitter.
// Contents: top-FSM state enum, character bit-count constants and the
// bit-period (baud divisor) constant function.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } frame_state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned START_BITS = 1;

    // Clocks per serial bit, integer-truncated (no fractional accumulation).
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-character UART serialiser: start bit, 8 data bits LSB first,
// optional parity bit (macro UART_TX_PARITY_EN), STOP_BITS stop bits,
// each bit lasting DIV clocks.
// Ports:
//   Clk, Reset  - clock, synchronous active-high reset
//   Send_En     - 1-cycle strobe, loads Data8 and starts a character
//   Data8       - character to send, sampled with Send_En
//   Tx_Done     - 1-cycle pulse during the last clock of the final stop bit
//   uart_tx     - serial line, idle high
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned DIV        = 434,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Send_En,
    input  logic [7:0] Data8,
    output logic       Tx_Done,
    output logic       uart_tx
);

`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned NBITS  = START_BITS + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int unsigned BAUD_W = $clog2(DIV);
    localparam int unsigned BIT_W  = $clog2(NBITS);

    // Early Tx_Done needs at least two clocks per bit.
    if (DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_byte_tx: unsupported parameter set");
    end

    logic [NBITS-1:0]  char_c;
    logic [NBITS-1:0]  tx_sh;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              active;
    logic              last_bit_c;

    // Whole character laid out LSB-first; stop bits come from the '1 fill.
    always_comb begin
        char_c                 = '1;
        char_c[0]              = 1'b0;
        char_c[DATA_BITS:1]    = Data8;
`ifdef UART_TX_PARITY_EN
        char_c[DATA_BITS+1]    = (^Data8) ^ 1'(PARITY_ODD);
`endif
    end

    assign last_bit_c = (bit_cnt == BIT_W'(NBITS - 1));
    assign uart_tx    = tx_sh[0];

    // Bit timing; Tx_Done leads the character end by one clock so the
    // parent can issue the next Send_En on the very edge this one ends.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tx_sh    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
            Tx_Done  <= 1'b0;
        end else begin
            Tx_Done <= active && last_bit_c && (baud_cnt == BAUD_W'(DIV - 2));
            if (Send_En) begin
                tx_sh    <= char_c;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                active   <= 1'b1;
            end else if (active) begin
                if (baud_cnt == BAUD_W'(DIV - 1)) begin
                    baud_cnt <= '0;
                    tx_sh    <= {1'b1, tx_sh[NBITS-1:1]};
                    if (last_bit_c) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_cnt <= baud_cnt + BAUD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: on a rising edge of Trans_Go (in IDLE) the
// NBYTES-wide Data word is latched and sent as NBYTES back-to-back
// characters, followed by a one-cycle Trans_Done.
// Optional feature macro: UART_TX_PARITY_EN (parity bit after data bit 7).
// Ports:
//   Clk, Reset  - clock, synchronous active-high reset
//   Data        - payload, sampled on the accepted start cycle
//   Trans_Go    - start request, rising-edge triggered
//   Trans_Done  - 1-cycle pulse at frame end
//   Busy        - high from acceptance through the Trans_Done cycle
//   uart_tx     - serial line, idle high
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned NBYTES     = 5,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [8*NBYTES-1:0] Data,
    input  logic                Trans_Go,
    output logic                Trans_Done,
    output logic                Busy,
    output logic                uart_tx
);

    localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if (NBYTES < 1 || NBYTES > 16 || MSB_FIRST > 1) begin : g_bad_cfg
        $error("uart_tx_frame: unsupported parameter set");
    end

    frame_state_t     state, state_n;
    logic             go_d;
    logic             armed;
    logic             start_c;
    logic             send_en_c;
    logic             tx_done;
    logic             last_byte_c;
    logic [W-1:0]     shreg;
    logic [W-1:0]     shifted_c;
    logic [IDX_W-1:0] idx;
    logic [7:0]       data8_c;

    // Character at the head of a word in the configured byte order.
    function automatic logic [7:0] head_byte(input logic [W-1:0] v);
        return (MSB_FIRST != 0) ? v[W-1 -: 8] : v[7:0];
    endfunction

    // armed blocks a Trans_Go that was already high during reset.
    assign start_c     = Trans_Go && !go_d && armed;
    assign last_byte_c = (idx == IDX_W'(NBYTES - 1));
    assign shifted_c   = (MSB_FIRST != 0) ? (shreg << 8) : (shreg >> 8);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and character launch; the next character starts on the
    // same edge the previous one completes.
    always_comb begin
        state_n   = state;
        send_en_c = 1'b0;
        data8_c   = head_byte(shifted_c);
        case (state)
            IDLE: begin
                if (start_c) begin
                    state_n   = SEND;
                    send_en_c = 1'b1;
                    data8_c   = head_byte(Data);
                end
            end
            SEND: begin
                if (tx_done) begin
                    if (last_byte_c) begin
                        state_n = DONE;
                    end else begin
                        send_en_c = 1'b1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Edge detect, payload shift register, byte index and status flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            go_d       <= 1'b0;
            armed      <= !Trans_Go;
            shreg      <= '0;
            idx        <= '0;
            Trans_Done <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            go_d       <= Trans_Go;
            armed      <= armed || !Trans_Go;
            Trans_Done <= (state_n == DONE);
            Busy       <= (state_n != IDLE);
            if (state == IDLE && start_c) begin
                shreg <= Data;
                idx   <= '0;
            end else if (state == SEND && tx_done && !last_byte_c) begin
                shreg <= shifted_c;
                idx   <= idx + IDX_W'(1);
            end
        end
    end

    uart_byte_tx #(
        .DIV        (DIV),
        .STOP_BITS  (STOP_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) u_byte_tx (
        .Clk     (Clk),
        .Reset   (Reset),
        .Send_En (send_en_c),
        .Data8   (data8_c),
        .Tx_Done (tx_done),
        .uart_tx (uart_tx)
    );

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. Three instances:
//   0: all defaults (DIV 434, 5 bytes, MSB first, 1 stop bit)
//   1: fast line (DIV 7), 5 bytes, LSB first, 2 stop bits, odd parity
//   2: DIV 434, 1 byte, 2 stop bits, even parity
// The expected line is rebuilt per clock from the character format rules.
`timescale 1ns/1ps
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  go;
    logic [2:0]  tx;
    logic [2:0]  done;
    logic [2:0]  busy;
    logic [39:0] dat_a;
    logic [39:0] dat_b;
    logic [7:0]  dat_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame u_a (
        .Clk(clk), .Reset(rst), .Data(dat_a), .Trans_Go(go[0]),
        .Trans_Done(done[0]), .Busy(busy[0]), .uart_tx(tx[0])
    );

    uart_tx_frame #(
        .CLK_FREQ(700), .BAUD(100), .NBYTES(5), .MSB_FIRST(0),
        .STOP_BITS(2), .PARITY_ODD(1)
    ) u_b (
        .Clk(clk), .Reset(rst), .Data(dat_b), .Trans_Go(go[1]),
        .Trans_Done(done[1]), .Busy(busy[1]), .uart_tx(tx[1])
    );

    uart_tx_frame #(
        .NBYTES(1), .STOP_BITS(2), .PARITY_ODD(0)
    ) u_c (
        .Clk(clk), .Reset(rst), .Data(dat_c), .Trans_Go(go[2]),
        .Trans_Done(done[2]), .Busy(busy[2]), .uart_tx(tx[2])
    );

    function automatic int cfg_div(input int s);
        return (s == 1) ? 7 : 434;
    endfunction
    function automatic int cfg_nb(input int s);
        return (s == 2) ? 1 : 5;
    endfunction
    function automatic int cfg_sb(input int s);
        return (s == 0) ? 1 : 2;
    endfunction
    function automatic bit cfg_msb(input int s);
        return (s != 1);
    endfunction
    function automatic bit cfg_odd(input int s);
        return (s == 1);
    endfunction
    function automatic int cfg_clen(input int s);
        return (1 + 8 + int'(P) + cfg_sb(s)) * cfg_div(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int s, input logic [39:0] d);
        case (s)
            0:       dat_a = d;
            1:       dat_b = d;
            default: dat_c = d[7:0];
        endcase
    endtask

    // Launch one frame on instance s and compare every line clock against
    // the reference waveform. mid_rise>0 adds a second Trans_Go rise at that
    // clock; hold_frames>0 keeps Trans_Go high that many extra frame times.
    task automatic run_frame(input int s, input logic [39:0] d, input int mid_rise,
                             input int hold_frames, input string tag);
        int         dv, n, nbit, clen, total;
        int         line_bad, done_bad, busy_bad, post_bad, post_len;
        int         ci, loc, bi;
        bit         exp_q[$];
        bit         lv;
        logic [7:0] bv;
        logic [7:0] exp_b [16];
        logic [7:0] obs_b;
        logic       obs_par;

        dv    = cfg_div(s);
        n     = cfg_nb(s);
        nbit  = 1 + 8 + int'(P) + cfg_sb(s);
        clen  = nbit * dv;
        total = n * clen;

        exp_q = {};
        for (int c = 0; c < n; c++) begin
            bv       = cfg_msb(s) ? d[8*(n-1-c) +: 8] : d[8*c +: 8];
            exp_b[c] = bv;
            for (int b = 0; b < nbit; b++) begin
                if (b == 0)                    lv = 1'b0;
                else if (b <= 8)               lv = bv[b-1];
                else if (b == 9 && P == 1)     lv = (^bv) ^ cfg_odd(s);
                else                           lv = 1'b1;
                repeat (dv) exp_q.push_back(lv);
            end
        end

        line_bad = 0; done_bad = 0; busy_bad = 0;
        obs_b = '0; obs_par = 1'b0;

        @(negedge clk);
        set_data(s, d);
        go[s] = 1'b1;
        @(negedge clk);
        for (int t = 0; t < total + 2; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 0 && hold_frames == 0) go[s] = 1'b0;
            if (t == 1) set_data(s, ~d);
            if (mid_rise > 0 && t == mid_rise)     go[s] = 1'b1;
            if (mid_rise > 0 && t == mid_rise + 3) go[s] = 1'b0;

            if (t < total) begin
                ci  = t / clen;
                loc = t % clen;
                bi  = loc / dv;
                if (tx[s] !== exp_q[t])  line_bad++;
                if (done[s] !== 1'b0)    done_bad++;
                if (busy[s] !== 1'b1)    busy_bad++;
                if (loc % dv == dv / 2) begin
                    if (bi >= 1 && bi <= 8) obs_b[bi-1] = tx[s];
                    if (bi == 9)            obs_par     = tx[s];
                end
                if (loc == clen - 1) begin
                    chk($sformatf("%s_byte%0d", tag, ci), 64'(obs_b), 64'(exp_b[ci]));
                    chk($sformatf("%s_line%0d", tag, ci), 64'(line_bad), 64'd0);
`ifdef UART_TX_PARITY_EN
                    chk($sformatf("%s_par%0d", tag, ci), 64'(obs_par),
                        64'((^exp_b[ci]) ^ cfg_odd(s)));
`endif
                    line_bad = 0;
                end
            end else if (t == total) begin
                chk({tag, "_done_pulse"}, 64'({done[s], busy[s], tx[s]}), 64'(3'b111));
            end else begin
                chk({tag, "_after_done"}, 64'({done[s], busy[s], tx[s]}), 64'(3'b001));
            end
        end
        chk({tag, "_no_early_done"}, 64'(done_bad), 64'd0);
        chk({tag, "_busy_held"}, 64'(busy_bad), 64'd0);

        post_len = (hold_frames > 0) ? hold_frames * total : 20;
        post_bad = 0;
        repeat (post_len) begin
            @(negedge clk);
            if (busy[s] !== 1'b0 || tx[s] !== 1'b1 || done[s] !== 1'b0) post_bad++;
        end
        go[s] = 1'b0;
        chk({tag, "_no_second_frame"}, 64'(post_bad), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Reset during the third character of instance 1 with Trans_Go held
    // high through the reset: line must go idle and no frame may start.
    task automatic reset_mid();
        int clen, bad;
        clen = cfg_clen(1);
        @(negedge clk);
        set_data(1, 40'h0f1e2d3c4b);
        go[1] = 1'b1;
        @(negedge clk);
        go[1] = 1'b0;
        repeat (2 * clen + clen / 2) @(negedge clk);
        chk("rst_pre_busy", 64'(busy[1]), 64'd1);
        go[1] = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_state", 64'({done[1], busy[1], tx[1]}), 64'(3'b001));
        bad = 0;
        repeat (3 * clen) begin
            @(negedge clk);
            if (busy[1] !== 1'b0 || done[1] !== 1'b0 || tx[1] !== 1'b1) bad++;
        end
        chk("rst_held_go_ignored", 64'(bad), 64'd0);
        go[1] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        go    = 3'b000;
        dat_a = '0;
        dat_b = '0;
        dat_c = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", 64'(tx), 64'(3'b111));
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        run_frame(0, 40'h123456789a, 0, 0, "a_msb_first");
        run_frame(1, 40'ha987654321, 0, 0, "b_lsb_first");
        run_frame(1, 40'({$urandom(), $urandom()}), 2 * cfg_clen(1) + cfg_clen(1) / 2, 0,
                  "b_mid_rise");
        run_frame(1, 40'({$urandom(), $urandom()}), 0, 3, "b_hold_go");
        reset_mid();
        run_frame(1, 40'({$urandom(), $urandom()}), 0, 0, "b_after_rst");
        run_frame(1, 40'h12_00_ff_12_80, 0, 0, "b_edge_bytes");
        for (int i = 0; i < 6; i++) begin
            run_frame(1, 40'({$urandom(), $urandom()}),
                      (i % 2 == 0) ? int'($urandom_range(1, 5 * cfg_clen(1) - 1)) : 0, 0,
                      $sformatf("b_rand%0d", i));
        end
        run_frame(2, 40'h12, 0, 0, "c_par_12");
        run_frame(2, 40'($urandom()), 0, 0, "c_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
